// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - MIPS ID stage: register file, control decode, load-use stall; stall counter under DECODE_STALL_CNT_EN
module decode_stage #(
    parameter int DATA_W    = 32,
    parameter int WB_BYPASS = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [63:0]       IF_ID,
    input  logic              flush,
    input  logic              wb_reg_write,
    input  logic [4:0]        wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    output logic              stall,
    output logic [1:0]        ID_EX_WB,
    output logic [2:0]        ID_EX_M,
    output logic [3:0]        ID_EX_EX,
    output logic [31:0]       ID_EX_pc4,
    output logic [DATA_W-1:0] ID_EX_rs_data,
    output logic [DATA_W-1:0] ID_EX_rt_data,
    output logic [DATA_W-1:0] ID_EX_imm,
    output logic [4:0]        ID_EX_rs,
    output logic [4:0]        ID_EX_rt,
    output logic [4:0]        ID_EX_rd,
    output logic              illegal,
    output logic [15:0]       stall_cnt
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [4:0]  rs_a;
    logic [4:0]  rt_a;
    logic [4:0]  rd_a;

    assign instr  = IF_ID[31:0];
    assign opcode = instr[31:26];
    assign rs_a   = instr[25:21];
    assign rt_a   = instr[20:16];
    assign rd_a   = instr[15:11];

    logic [DATA_W-1:0] regs_q [32];
    logic [DATA_W-1:0] regs_d [32];
    logic [DATA_W-1:0] rs_rd_data;
    logic [DATA_W-1:0] rt_rd_data;

    logic [1:0]        ctl_wb;
    logic [2:0]        ctl_m;
    logic [3:0]        ctl_ex;
    logic              ctl_illegal;
    logic              bubble;

    logic [1:0]        id_ex_wb_q,  id_ex_wb_d;
    logic [2:0]        id_ex_m_q,   id_ex_m_d;
    logic [3:0]        id_ex_ex_q,  id_ex_ex_d;
    logic [31:0]       id_ex_pc4_q, id_ex_pc4_d;
    logic [DATA_W-1:0] id_ex_rs_data_q, id_ex_rs_data_d;
    logic [DATA_W-1:0] id_ex_rt_data_q, id_ex_rt_data_d;
    logic [DATA_W-1:0] id_ex_imm_q, id_ex_imm_d;
    logic [4:0]        id_ex_rs_q,  id_ex_rs_d;
    logic [4:0]        id_ex_rt_q,  id_ex_rt_d;
    logic [4:0]        id_ex_rd_q,  id_ex_rd_d;
    logic              illegal_q,   illegal_d;

    // Register file next state: single writeback port, $0 is never written
    always_comb begin
        for (int i = 0; i < 32; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (wb_reg_write && (wb_rd != 5'd0)) begin
            regs_d[wb_rd] = wb_data;
        end
    end

    // Register file storage, cleared by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Read port A: $0 reads zero, optional same-cycle writeback forwarding
    always_comb begin
        rs_rd_data = regs_q[rs_a];
        if (rs_a == 5'd0) begin
            rs_rd_data = '0;
        end else if ((WB_BYPASS != 0) && wb_reg_write && (wb_rd == rs_a)) begin
            rs_rd_data = wb_data;
        end
    end

    // Read port B: same rules as port A
    always_comb begin
        rt_rd_data = regs_q[rt_a];
        if (rt_a == 5'd0) begin
            rt_rd_data = '0;
        end else if ((WB_BYPASS != 0) && wb_reg_write && (wb_rd == rt_a)) begin
            rt_rd_data = wb_data;
        end
    end

    // Main control decode from the opcode; unknown opcodes raise illegal
    always_comb begin
        ctl_wb      = 2'b00;
        ctl_m       = 3'b000;
        ctl_ex      = 4'b0000;
        ctl_illegal = 1'b0;
        case (opcode)
            OP_RTYPE: begin ctl_wb = 2'b10; ctl_m = 3'b000; ctl_ex = 4'b1100; end
            OP_LW:    begin ctl_wb = 2'b11; ctl_m = 3'b010; ctl_ex = 4'b0001; end
            OP_SW:    begin ctl_wb = 2'b00; ctl_m = 3'b001; ctl_ex = 4'b0001; end
            OP_BEQ:   begin ctl_wb = 2'b00; ctl_m = 3'b100; ctl_ex = 4'b0010; end
            OP_ADDI:  begin ctl_wb = 2'b10; ctl_m = 3'b000; ctl_ex = 4'b0001; end
            default:  ctl_illegal = 1'b1;
        endcase
    end

    // A load in EX whose target is a source here must wait one cycle; a flush overrides it
    assign stall  = !flush && id_ex_m_q[1] && (id_ex_rt_q != 5'd0)
                    && ((id_ex_rt_q == rs_a) || (id_ex_rt_q == rt_a));
    assign bubble = stall || flush;

    // ID/EX next state: a bubble clears control only, data fields load regardless
    always_comb begin
        id_ex_wb_d      = bubble ? 2'b00   : ctl_wb;
        id_ex_m_d       = bubble ? 3'b000  : ctl_m;
        id_ex_ex_d      = bubble ? 4'b0000 : ctl_ex;
        illegal_d       = bubble ? 1'b0    : ctl_illegal;
        id_ex_pc4_d     = IF_ID[63:32];
        id_ex_rs_data_d = rs_rd_data;
        id_ex_rt_data_d = rt_rd_data;
        id_ex_imm_d     = {{(DATA_W-16){instr[15]}}, instr[15:0]};
        id_ex_rs_d      = rs_a;
        id_ex_rt_d      = rt_a;
        id_ex_rd_d      = rd_a;
    end

    // ID/EX pipeline register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            id_ex_wb_q      <= '0;
            id_ex_m_q       <= '0;
            id_ex_ex_q      <= '0;
            id_ex_pc4_q     <= '0;
            id_ex_rs_data_q <= '0;
            id_ex_rt_data_q <= '0;
            id_ex_imm_q     <= '0;
            id_ex_rs_q      <= '0;
            id_ex_rt_q      <= '0;
            id_ex_rd_q      <= '0;
            illegal_q       <= 1'b0;
        end else begin
            id_ex_wb_q      <= id_ex_wb_d;
            id_ex_m_q       <= id_ex_m_d;
            id_ex_ex_q      <= id_ex_ex_d;
            id_ex_pc4_q     <= id_ex_pc4_d;
            id_ex_rs_data_q <= id_ex_rs_data_d;
            id_ex_rt_data_q <= id_ex_rt_data_d;
            id_ex_imm_q     <= id_ex_imm_d;
            id_ex_rs_q      <= id_ex_rs_d;
            id_ex_rt_q      <= id_ex_rt_d;
            id_ex_rd_q      <= id_ex_rd_d;
            illegal_q       <= illegal_d;
        end
    end

    assign ID_EX_WB      = id_ex_wb_q;
    assign ID_EX_M       = id_ex_m_q;
    assign ID_EX_EX      = id_ex_ex_q;
    assign ID_EX_pc4     = id_ex_pc4_q;
    assign ID_EX_rs_data = id_ex_rs_data_q;
    assign ID_EX_rt_data = id_ex_rt_data_q;
    assign ID_EX_imm     = id_ex_imm_q;
    assign ID_EX_rs      = id_ex_rs_q;
    assign ID_EX_rt      = id_ex_rt_q;
    assign ID_EX_rd      = id_ex_rd_q;
    assign illegal       = illegal_q;

`ifdef DECODE_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Saturating count of stalled cycles
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    // Stall counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= 16'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - self-checking bench for decode_stage (both WB_BYPASS settings)
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] IF_ID;
    logic        flush;
    logic        wb_reg_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    logic        d1_stall, d0_stall;
    logic [1:0]  d1_wb, d0_wb;
    logic [2:0]  d1_m, d0_m;
    logic [3:0]  d1_ex, d0_ex;
    logic [31:0] d1_pc4, d0_pc4, d1_rsd, d0_rsd, d1_rtd, d0_rtd, d1_imm, d0_imm;
    logic [4:0]  d1_rs, d0_rs, d1_rt, d0_rt, d1_rd, d0_rd;
    logic        d1_ill, d0_ill;
    logic [15:0] d1_cnt, d0_cnt;

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_en   = 1'b0;

    always #5 clk = ~clk;

    decode_stage #(.DATA_W(32), .WB_BYPASS(1)) u_dut_byp (
        .clk(clk), .reset(reset), .IF_ID(IF_ID), .flush(flush),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
        .stall(d1_stall), .ID_EX_WB(d1_wb), .ID_EX_M(d1_m), .ID_EX_EX(d1_ex),
        .ID_EX_pc4(d1_pc4), .ID_EX_rs_data(d1_rsd), .ID_EX_rt_data(d1_rtd),
        .ID_EX_imm(d1_imm), .ID_EX_rs(d1_rs), .ID_EX_rt(d1_rt), .ID_EX_rd(d1_rd),
        .illegal(d1_ill), .stall_cnt(d1_cnt)
    );

    decode_stage #(.DATA_W(32), .WB_BYPASS(0)) u_dut_nobyp (
        .clk(clk), .reset(reset), .IF_ID(IF_ID), .flush(flush),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
        .stall(d0_stall), .ID_EX_WB(d0_wb), .ID_EX_M(d0_m), .ID_EX_EX(d0_ex),
        .ID_EX_pc4(d0_pc4), .ID_EX_rs_data(d0_rsd), .ID_EX_rt_data(d0_rtd),
        .ID_EX_imm(d0_imm), .ID_EX_rs(d0_rs), .ID_EX_rt(d0_rt), .ID_EX_rd(d0_rd),
        .illegal(d0_ill), .stall_cnt(d0_cnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_regs [32];
    logic [1:0]  m_wb = '0;
    logic [2:0]  m_m = '0;
    logic [3:0]  m_ex = '0;
    logic [31:0] m_pc4 = '0, m_imm = '0;
    logic [31:0] m_rsd1 = '0, m_rsd0 = '0, m_rtd1 = '0, m_rtd0 = '0;
    logic [4:0]  m_rs = '0, m_rt = '0, m_rd = '0;
    logic        m_ill = 1'b0;
    logic [15:0] m_cnt = '0;

    // {illegal, WB, M, EX} for each opcode
    function automatic logic [9:0] ctl_of(input logic [5:0] op);
        case (op)
            6'h00:   return 10'b0_10_000_1100;
            6'h23:   return 10'b0_11_010_0001;
            6'h2B:   return 10'b0_00_001_0001;
            6'h04:   return 10'b0_00_100_0010;
            6'h08:   return 10'b0_10_000_0001;
            default: return 10'b1_00_000_0000;
        endcase
    endfunction

    // load in EX targets a source register of the instruction in decode
    function automatic logic model_stall();
        if (flush) return 1'b0;
        return m_m[1] && (m_rt != 5'd0) && (m_rt == IF_ID[25:21] || m_rt == IF_ID[20:16]);
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] a, input bit byp);
        if (a == 5'd0) return 32'd0;
        if (byp && wb_reg_write && wb_rd == a) return wb_data;
        return m_regs[a];
    endfunction

    always @(posedge clk or posedge reset) begin : model
        logic [9:0]  c;
        logic        hz;
        logic [31:0] ins;
        if (reset) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
            m_wb = '0; m_m = '0; m_ex = '0; m_pc4 = '0; m_imm = '0;
            m_rsd1 = '0; m_rsd0 = '0; m_rtd1 = '0; m_rtd0 = '0;
            m_rs = '0; m_rt = '0; m_rd = '0; m_ill = 1'b0; m_cnt = '0;
        end else begin
            ins = IF_ID[31:0];
            hz  = model_stall();
            c   = ctl_of(ins[31:26]);
            if (hz || flush) c = 10'd0;
            m_rsd1 = model_read(ins[25:21], 1'b1);
            m_rsd0 = model_read(ins[25:21], 1'b0);
            m_rtd1 = model_read(ins[20:16], 1'b1);
            m_rtd0 = model_read(ins[20:16], 1'b0);
            {m_ill, m_wb, m_m, m_ex} = c;
            m_pc4 = IF_ID[63:32];
            m_imm = {{16{ins[15]}}, ins[15:0]};
            m_rs  = ins[25:21];
            m_rt  = ins[20:16];
            m_rd  = ins[15:11];
            if (wb_reg_write && wb_rd != 5'd0) m_regs[wb_rd] = wb_data;
            if (hz && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        end
    end

    function automatic logic [15:0] exp_cnt();
`ifdef DECODE_STALL_CNT_EN
        return m_cnt;
`else
        return 16'd0;
`endif
    endfunction

    task automatic cmp_dut(input string tag, input bit byp, input logic st,
                           input logic [1:0] wb, input logic [2:0] m, input logic [3:0] ex,
                           input logic [31:0] pc4, input logic [31:0] rsd, input logic [31:0] rtd,
                           input logic [31:0] imm, input logic [4:0] rs, input logic [4:0] rt,
                           input logic [4:0] rd, input logic ill, input logic [15:0] cnt);
        chk({tag, ".stall"},   st,  model_stall());
        chk({tag, ".wb"},      wb,  m_wb);
        chk({tag, ".m"},       m,   m_m);
        chk({tag, ".ex"},      ex,  m_ex);
        chk({tag, ".pc4"},     pc4, m_pc4);
        chk({tag, ".rs_data"}, rsd, byp ? m_rsd1 : m_rsd0);
        chk({tag, ".rt_data"}, rtd, byp ? m_rtd1 : m_rtd0);
        chk({tag, ".imm"},     imm, m_imm);
        chk({tag, ".rs"},      rs,  m_rs);
        chk({tag, ".rt"},      rt,  m_rt);
        chk({tag, ".rd"},      rd,  m_rd);
        chk({tag, ".illegal"}, ill, m_ill);
        chk({tag, ".cnt"},     cnt, exp_cnt());
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            cmp_dut("byp", 1'b1, d1_stall, d1_wb, d1_m, d1_ex, d1_pc4, d1_rsd, d1_rtd,
                    d1_imm, d1_rs, d1_rt, d1_rd, d1_ill, d1_cnt);
            cmp_dut("nobyp", 1'b0, d0_stall, d0_wb, d0_m, d0_ex, d0_pc4, d0_rsd, d0_rtd,
                    d0_imm, d0_rs, d0_rt, d0_rd, d0_ill, d0_cnt);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic drive(input logic [63:0] ifid, input logic fl, input logic we,
                         input logic [4:0] rd, input logic [31:0] data);
        IF_ID = ifid; flush = fl; wb_reg_write = we; wb_rd = rd; wb_data = data;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #2;
    endtask

    localparam logic [31:0] LW_2_4_1  = 32'h8C220004;
    localparam logic [31:0] ADD_3_2_4 = 32'h00441820;

    initial begin
        reset = 1'b0; IF_ID = '0; flush = 1'b0; wb_reg_write = 1'b0; wb_rd = '0; wb_data = '0;
        #1 reset = 1'b1;
        #1;
        chk("reset_wb", d1_wb, 2'b00);
        chk("reset_m", d1_m, 3'b000);
        chk("reset_rs_data", d1_rsd, 32'd0);
        chk("reset_illegal", d1_ill, 1'b0);
        chk("reset_cnt", d1_cnt, 16'd0);
        cmp_en = 1'b1;
        @(negedge clk); #2 reset = 1'b0;

        drive(64'd0, 1'b0, 1'b1, 5'd1, 32'd5); tick();
        drive({32'd8, LW_2_4_1}, 1'b0, 1'b1, 5'd7, 32'h11111111);
        chk("lw_stall_in_decode", d1_stall, 1'b0);
        tick();
        chk("lw_wb", d1_wb, 2'b11);
        chk("lw_m", d1_m, 3'b010);
        chk("lw_ex", d1_ex, 4'b0001);
        chk("lw_rs_data", d1_rsd, 32'd5);
        chk("lw_imm", d1_imm, 32'd4);
        chk("lw_rt", d1_rt, 5'd2);
        chk("lw_pc4", d1_pc4, 32'd8);

        drive({32'd12, ADD_3_2_4}, 1'b0, 1'b0, 5'd0, 32'd0);
        chk("hazard_stall", d1_stall, 1'b1);
        tick();
        chk("bubble_ctl", {d1_wb, d1_m, d1_ex}, 9'd0);
        chk("bubble_rs_loaded", d1_rs, 5'd2);
        chk("stall_released", d1_stall, 1'b0);
        tick();
        chk("add_ex", d1_ex, 4'b1100);
        chk("add_wb", d1_wb, 2'b10);
        chk("add_rd", d1_rd, 5'd3);
`ifdef DECODE_STALL_CNT_EN
        chk("stall_cnt_one", d1_cnt, 16'd1);
`else
        chk("stall_cnt_zero", d1_cnt, 16'd0);
`endif

        drive({32'd16, 32'h00E04020}, 1'b0, 1'b1, 5'd7, 32'hDEADBEEF); tick();
        chk("bypass_on", d1_rsd, 32'hDEADBEEF);
        chk("bypass_off", d0_rsd, 32'h11111111);
        drive({32'd16, 32'h00E04020}, 1'b0, 1'b0, 5'd0, 32'd0); tick();
        chk("bypass_off_later", d0_rsd, 32'hDEADBEEF);

        drive({32'd20, 32'h20050010}, 1'b0, 1'b1, 5'd0, 32'h1234); tick();
        chk("r0_byp", d1_rsd, 32'd0);
        chk("r0_nobyp", d0_rsd, 32'd0);
        chk("addi_imm", d1_imm, 32'h10);
        chk("addi_ex", d1_ex, 4'b0001);

        drive({32'd24, LW_2_4_1}, 1'b0, 1'b0, 5'd0, 32'd0); tick();
        drive({32'd28, ADD_3_2_4}, 1'b1, 1'b1, 5'd9, 32'd99);
        chk("flush_kills_stall", d1_stall, 1'b0);
        tick();
        chk("flush_ctl", {d1_wb, d1_m, d1_ex}, 9'd0);
        drive({32'd32, 32'h01205020}, 1'b0, 1'b0, 5'd0, 32'd0); tick();
        chk("write_during_flush", d1_rsd, 32'd99);

        drive({32'd36, 32'h8C200000}, 1'b0, 1'b0, 5'd0, 32'd0); tick();
        drive({32'd40, 32'h00001820}, 1'b0, 1'b0, 5'd0, 32'd0);
        chk("lw_r0_no_stall", d1_stall, 1'b0);
        tick();

        drive({32'd44, 32'hFC000000}, 1'b0, 1'b0, 5'd0, 32'd0); tick();
        chk("illegal_set", d1_ill, 1'b1);
        chk("illegal_ctl", {d1_wb, d1_m, d1_ex}, 9'd0);
        drive({32'd48, 32'h00000000}, 1'b0, 1'b0, 5'd0, 32'd0); tick();
        chk("illegal_clear", d1_ill, 1'b0);
        chk("nop_ctl", {d1_wb, d1_m, d1_ex}, 9'b10_000_1100);

        drive({32'd52, LW_2_4_1}, 1'b0, 1'b0, 5'd0, 32'd0); tick();
        drive({32'd56, ADD_3_2_4}, 1'b0, 1'b0, 5'd0, 32'd0);
        chk("pre_reset_stall", d1_stall, 1'b1);
        reset = 1'b1;
        #1;
        chk("async_reset_stall", d1_stall, 1'b0);
        chk("async_reset_ctl", {d1_wb, d1_m, d1_ex}, 9'd0);
        chk("async_reset_pc4", d1_pc4, 32'd0);
        chk("async_reset_rt", d1_rt, 5'd0);
        chk("async_reset_cnt", d1_cnt, 16'd0);
        @(negedge clk); #2 reset = 1'b0;
        drive({32'd60, 32'h00220820}, 1'b0, 1'b0, 5'd0, 32'd0); tick();
        chk("regs_cleared", d1_rsd, 32'd0);
        tick();

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Instruction-decode stage of the 5-stage MIPS pipeline; sits directly downstream of the fetch stage and consumes the 64-bit IF/ID word (PC+4 in [63:32], instruction in [31:0]).
- Contains the 32x32 register file, main control decode, sign extension and load-use hazard detection.
- Drives a registered ID/EX bundle to the execute stage, and a stall to fetch.

Parameters:
- DATA_W, 32, datapath width; only 32 is supported.
- WB_BYPASS, 1, 1 = a read of a register written by writeback in the same cycle returns the write data; 0 = returns the old contents.

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- IF_ID  in  64  [63:32] PC+4, [31:0] instruction.
- flush  in  1  branch taken (PCSrc from memory stage); squashes the instruction in decode.
- wb_reg_write  in  1  writeback write enable.
- wb_rd  in  5  writeback destination register.
- wb_data  in  32  writeback data.
- stall  out  1  combinational; 1 = fetch must hold PC and IF/ID this cycle.
- ID_EX_WB  out  2  [1] RegWrite, [0] MemtoReg.
- ID_EX_M  out  3  [2] Branch, [1] MemRead, [0] MemWrite.
- ID_EX_EX  out  4  [3] RegDst, [2:1] ALUOp, [0] ALUSrc.
- ID_EX_pc4  out  32  PC+4.
- ID_EX_rs_data  out  32  register file read port A.
- ID_EX_rt_data  out  32  register file read port B.
- ID_EX_imm  out  32  sign-extended instr[15:0].
- ID_EX_rs  out  5  instr[25:21].
- ID_EX_rt  out  5  instr[20:16].
- ID_EX_rd  out  5  instr[15:11].
- illegal  out  1  registered; 1 = the opcode now in EX was unrecognised.
- stall_cnt  out  16  stall-cycle counter (see Optional Feature).

Behaviour:
- Reset (asynchronous): all ID_EX_* outputs, illegal and stall_cnt are 0, and all 32 registers are 0. The ID/EX register stays cleared until the first rising edge after reset deasserts.
- Latency: one cycle. The instruction present on IF_ID at edge N appears on ID_EX_* after edge N.
- Control decode on opcode instr[31:26], giving {WB, M, EX}:
  - 0x00 R-type: WB=10, M=000, EX=1100.
  - 0x23 lw: WB=11, M=010, EX=0001.
  - 0x2B sw: WB=00, M=001, EX=0001.
  - 0x04 beq: WB=00, M=100, EX=0010.
  - 0x08 addi: WB=10, M=000, EX=0001.
  - Any other opcode: all control bits 0 and illegal=1.
- Register file:
  - Write on the rising edge when wb_reg_write=1 and wb_rd!=0.
  - Writes to $0 are ignored, and $0 always reads 0.
  - Reads are combinational, with the WB_BYPASS rule applied when wb_rd matches the read address and wb_rd!=0.
- Load-use hazard: stall=1 when ID_EX_M[1]=1, ID_EX_rt!=0, and ID_EX_rt equals instr[25:21] or instr[20:16], and flush=0.
- When stall=1, the next edge loads a bubble: WB, M, EX and illegal are 0; data fields are loaded normally. The next cycle re-evaluates with the same IF_ID, since fetch holds it.
- When flush=1, the next edge loads a bubble, and stall is forced to 0. Flush has priority over stall.
- Simultaneous flush and writeback: the register write still occurs.
- All-zero instruction (sll $0,$0,0) decodes as R-type writing $0; no stall can result from it because rt=0.
- Reset asserted mid-stall: stall drops immediately, since ID_EX_M clears asynchronously.

Optional Feature:
- Macro: DECODE_STALL_CNT_EN.
- Defined: stall_cnt increments by 1 on every rising edge where stall=1, saturating at 16'hFFFF. It is cleared by reset.
- Undefined: stall_cnt is tied to 0 and no counter logic is synthesised.

Test Plan:
- Reset, then IF_ID={32'd8, 32'h8C220004} (lw $2,4($1)), $1 preloaded to 5 via writeback: after one clk, ID_EX_WB=11, M=010, EX=0001, rs_data=5, imm=4, rt=2, stall=0.
- lw $2 followed by add $3,$2,$4 (32'h00441820): stall=1 for exactly one cycle. The bubble has WB/M/EX=0. The add then issues with EX=1100; stall_cnt=1 with the macro defined, 0 without.
- Writeback of $7=32'hDEADBEEF in the same cycle decode reads $7: ID_EX_rs_data=DEADBEEF with WB_BYPASS=1, and the old value with WB_BYPASS=0.
- Writeback to $0 with data 32'h1234, then read $0: rs_data=0.
- flush=1 on the same cycle as a load-use hazard: stall=0 and the next ID_EX control is all zero.
- Opcode 0x3F: illegal=1 and all control bits 0. Assert reset mid-stream: all outputs are 0 immediately, without waiting for clk.
